// File: rtl/sort_arb_pkg.sv
// Shared types and constants for the sort_arbiter front/back end of the packet sorter.
package sort_arb_pkg;

  typedef enum logic [1:0] {IDLE, FWD, DROP, DRAIN} state_t;

  function automatic int wcnt_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  localparam int          WCNT_W     = wcnt_width(250);
  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/sort_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after the pointer, wrapping at N_CH.
module rr_picker #(
  parameter  int N_CH = 4,
  localparam int CHW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CHW-1:0]  i_ptr,
  output logic [CHW-1:0]  o_idx,
  output logic            o_vld
);

  int             w_j;
  logic [CHW-1:0] w_jj;

  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = 0;
    w_jj  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N_CH) w_j = w_j - N_CH;
      w_jj = CHW'(w_j);
      if (!o_vld && i_req[w_jj]) begin
        o_vld = 1'b1;
        o_idx = w_jj;
      end
    end
  end

endmodule

// File: rtl/sort_arbiter.sv
// Round-robin sharing of one single-packet sorter between N_CH Avalon-ST sources.
// Optional stall watchdog is enabled with the macro SORT_ARB_WATCHDOG_EN.
module sort_arbiter
  import sort_arb_pkg::*;
#(
  parameter  int DWIDTH      = 16,
  parameter  int N_CH        = 4,
  parameter  int MAX_PKT_LEN = 250,
  localparam int CHW         = $clog2(N_CH)
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [N_CH-1:0][DWIDTH-1:0] snk_data_i,
  input  logic [N_CH-1:0]             snk_startofpacket_i,
  input  logic [N_CH-1:0]             snk_endofpacket_i,
  input  logic [N_CH-1:0]             snk_valid_i,
  output logic [N_CH-1:0]             snk_ready_o,
  output logic [DWIDTH-1:0]           srt_data_o,
  output logic                        srt_startofpacket_o,
  output logic                        srt_endofpacket_o,
  output logic                        srt_valid_o,
  input  logic                        srt_ready_i,
  input  logic [DWIDTH-1:0]           res_data_i,
  input  logic                        res_startofpacket_i,
  input  logic                        res_endofpacket_i,
  input  logic                        res_valid_i,
  output logic                        res_ready_o,
  output logic [DWIDTH-1:0]           src_data_o,
  output logic                        src_startofpacket_o,
  output logic                        src_endofpacket_o,
  output logic                        src_valid_o,
  input  logic                        src_ready_i,
  output logic [CHW-1:0]              src_channel_o,
  output logic                        trunc_o
);

  localparam int             WCW    = wcnt_width(MAX_PKT_LEN);
  localparam logic [WCW-1:0] LAST_W = WCW'(MAX_PKT_LEN - 1);

  state_t          r_state, w_next;
  logic [CHW-1:0]  r_grant, r_rr_ptr, w_pick_idx;
  logic            w_pick_vld;
  logic [WCW-1:0]  r_wcnt;
  logic [N_CH-1:0] w_req;
  logic            w_in_xfer, w_in_eop, w_at_last, w_res_last, w_wdog_fire;

  assign w_req      = snk_valid_i & snk_startofpacket_i;
  assign w_in_xfer  = snk_valid_i[r_grant] & snk_ready_o[r_grant];
  assign w_in_eop   = snk_endofpacket_i[r_grant];
  assign w_at_last  = (r_wcnt == LAST_W);
  assign w_res_last = res_valid_i & src_ready_i & res_endofpacket_i;

  rr_picker #(.N_CH(N_CH)) u_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

`ifdef SORT_ARB_WATCHDOG_EN
  logic [15:0] r_wdog;
  assign w_wdog_fire = ((r_state == FWD) || (r_state == DROP)) && (r_wdog == WDOG_LIMIT);

  // Saturates at the limit so an injected EOP can wait for the sorter to accept it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wdog <= '0;
    end else if (((r_state != FWD) && (r_state != DROP)) || w_in_xfer) begin
      r_wdog <= '0;
    end else if (r_wdog != WDOG_LIMIT) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  assign w_wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_wcnt   <= '0;
    end else if ((r_state == IDLE) && w_pick_vld) begin
      r_grant  <= w_pick_idx;
      r_rr_ptr <= (w_pick_idx == CHW'(N_CH - 1)) ? '0 : w_pick_idx + 1'b1;
      r_wcnt   <= '0;
    end else if ((r_state == FWD) && w_in_xfer) begin
      r_wcnt   <= r_wcnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_pick_vld) w_next = FWD;
      FWD: begin
        if (w_wdog_fire) begin
          if (srt_ready_i) w_next = DRAIN;
        end else if (w_in_xfer) begin
          if (w_in_eop)       w_next = DRAIN;
          else if (w_at_last) w_next = DROP;
        end
      end
      DROP:  if (w_wdog_fire || (w_in_xfer && w_in_eop)) w_next = DRAIN;
      DRAIN: if (w_res_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    snk_ready_o         = '0;
    srt_data_o          = '0;
    srt_startofpacket_o = 1'b0;
    srt_endofpacket_o   = 1'b0;
    srt_valid_o         = 1'b0;
    res_ready_o         = 1'b0;
    src_data_o          = '0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    src_valid_o         = 1'b0;
    src_channel_o       = '0;
    trunc_o             = 1'b0;
    unique case (r_state)
      FWD: begin
        if (w_wdog_fire) begin
          srt_valid_o       = 1'b1;
          srt_endofpacket_o = 1'b1;
          trunc_o           = srt_ready_i;
        end else begin
          // The word at the length limit is closed off as the packet's last word.
          srt_data_o           = snk_data_i[r_grant];
          srt_startofpacket_o  = snk_startofpacket_i[r_grant];
          srt_endofpacket_o    = snk_endofpacket_i[r_grant] | w_at_last;
          srt_valid_o          = snk_valid_i[r_grant];
          snk_ready_o[r_grant] = srt_ready_i;
          trunc_o              = snk_valid_i[r_grant] & srt_ready_i & w_at_last
                                 & ~snk_endofpacket_i[r_grant];
        end
      end
      DROP: begin
        snk_ready_o[r_grant] = ~w_wdog_fire;
        trunc_o              = w_wdog_fire;
      end
      DRAIN: begin
        src_data_o          = res_data_i;
        src_startofpacket_o = res_startofpacket_i;
        src_endofpacket_o   = res_endofpacket_i;
        src_valid_o         = res_valid_i;
        res_ready_o         = src_ready_i;
        src_channel_o       = r_grant;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sort_arbiter.sv
// Scoreboard bench for sort_arbiter with a behavioural single-packet ascending sorter.
`timescale 1ns/1ps
module tb_sort_arbiter;
  localparam int DW = 16, NC = 4, MAXL = 250, CW = 2;

  typedef struct packed {logic [15:0] d; logic sop; logic eop;} wd_t;
  typedef struct packed {logic [15:0] d; logic sop; logic eop; logic [CW-1:0] ch;} ow_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [NC-1:0][DW-1:0] snk_data = '0;
  logic [NC-1:0] snk_sop = '0, snk_eop = '0, snk_valid = '0, snk_ready;
  logic [DW-1:0] srt_data; logic srt_sop, srt_eop, srt_valid; logic srt_ready = 1'b1;
  logic [DW-1:0] res_data = '0; logic res_sop = 1'b0, res_eop = 1'b0, res_valid = 1'b0; logic res_ready;
  logic [DW-1:0] src_data; logic src_sop, src_eop, src_valid; logic src_ready = 1'b1;
  logic [CW-1:0] src_ch; logic trunc;

  always #5 clk = ~clk;

  sort_arbiter #(.DWIDTH(DW), .N_CH(NC), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .arst_i(arst),
    .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
    .snk_valid_i(snk_valid), .snk_ready_o(snk_ready),
    .srt_data_o(srt_data), .srt_startofpacket_o(srt_sop), .srt_endofpacket_o(srt_eop),
    .srt_valid_o(srt_valid), .srt_ready_i(srt_ready),
    .res_data_i(res_data), .res_startofpacket_i(res_sop), .res_endofpacket_i(res_eop),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .src_data_o(src_data), .src_startofpacket_o(src_sop), .src_endofpacket_o(src_eop),
    .src_valid_o(src_valid), .src_ready_i(src_ready), .src_channel_o(src_ch), .trunc_o(trunc)
  );

  wd_t ch_q[NC][$];
  wd_t exp_srt[$];
  ow_t exp_src[$];
  logic [15:0] pkt[$];
  logic [15:0] srtd[$];
  int n_cmp = 0, n_bad = 0, trunc_cnt = 0, srt_cnt = 0;
  bit toggle_mode = 0, in_flight = 0, drop_mode = 0;
  logic [NC-1:0] chx = '0;
  logic [15:0] sbuf[512];
  logic [15:0] stmp;
  int sn = 0, sk = 0;
  bit souting = 0, sgot_eop = 0, sres_x = 0;
  wd_t m_w;
  ow_t m_o;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Source drivers and sorter model: drive at negedge, sample handshakes 1ns later.
  always begin
    @(negedge clk);
    if (arst) begin
      sn = 0; sk = 0; souting = 0; sgot_eop = 0; sres_x = 0;
    end else begin
      if (sgot_eop) begin
        for (int i = 0; i < sn - 1; i++)
          for (int j = 0; j < sn - 1 - i; j++)
            if (sbuf[j] > sbuf[j+1]) begin stmp = sbuf[j]; sbuf[j] = sbuf[j+1]; sbuf[j+1] = stmp; end
        souting = 1; sk = 0; sgot_eop = 0;
      end
      if (sres_x) begin
        sk++;
        if (sk == sn) begin souting = 0; sn = 0; sk = 0; end
        sres_x = 0;
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (chx[c] && ch_q[c].size() > 0) void'(ch_q[c].pop_front());
      if (ch_q[c].size() > 0) begin
        snk_valid[c] = 1'b1; snk_data[c] = ch_q[c][0].d;
        snk_sop[c] = ch_q[c][0].sop; snk_eop[c] = ch_q[c][0].eop;
      end else begin
        snk_valid[c] = 1'b0; snk_data[c] = '0; snk_sop[c] = 1'b0; snk_eop[c] = 1'b0;
      end
    end
    srt_ready = !souting;
    res_valid = souting;
    res_data  = souting ? sbuf[sk] : '0;
    res_sop   = souting && (sk == 0);
    res_eop   = souting && (sk == sn - 1);
    src_ready = toggle_mode ? ~src_ready : 1'b1;
    #1;
    chx = snk_valid & snk_ready;
    if (!arst && srt_valid && srt_ready) begin
      sbuf[sn] = srt_data; sn++;
      if (srt_eop) sgot_eop = 1;
    end
    sres_x = !arst && res_valid && res_ready;
  end

  // Monitor: pops expected words whenever a handshake is about to complete.
  always begin
    @(negedge clk); #1;
    if (arst) begin
      in_flight = 0; drop_mode = 0;
    end else begin
      if (drop_mode) begin
        check("drop_ready_ch2", 64'({snk_ready[2], srt_valid}), 64'(2'b10));
        if (snk_valid[2] && snk_eop[2]) drop_mode = 0;
      end
      if (trunc) begin trunc_cnt++; drop_mode = 1; end
      if (srt_valid && srt_ready) begin
        srt_cnt++;
        if (exp_srt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL srt_unexpected: got word 0x%0h with none expected", srt_data);
        end else begin
          m_w = exp_srt.pop_front();
          check("srt_word", 64'({srt_data, srt_sop, srt_eop, in_flight}), 64'({m_w, 1'b0}));
        end
        if (srt_eop) in_flight = 1;
      end
      if (src_valid) check("res_ready_follows", 64'(res_ready), 64'(src_ready));
      if (src_valid && src_ready) begin
        if (exp_src.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL src_unexpected: got word 0x%0h ch %0d with none expected", src_data, src_ch);
        end else begin
          m_o = exp_src.pop_front();
          check("src_word", 64'({src_data, src_sop, src_eop, src_ch}), 64'(m_o));
        end
        if (src_eop) in_flight = 0;
      end
    end
  end

  task automatic push_pkt(input int c, input int nsrt);
    wd_t w;
    for (int i = 0; i < pkt.size(); i++) begin
      w.d = pkt[i]; w.sop = (i == 0); w.eop = (i == pkt.size() - 1);
      ch_q[c].push_back(w);
      if (i < nsrt) begin
        w.eop = w.eop || (i == MAXL - 1);
        exp_srt.push_back(w);
      end
    end
  endtask

  task automatic push_res(input int c);
    ow_t o;
    for (int i = 0; i < srtd.size(); i++) begin
      o.d = srtd[i]; o.sop = (i == 0); o.eop = (i == srtd.size() - 1); o.ch = CW'(c);
      exp_src.push_back(o);
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int left;
    left = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #2;
      left = exp_src.size() + exp_srt.size();
      for (int c = 0; c < NC; c++) left += ch_q[c].size();
      if (left == 0) break;
    end
    check({nm, "_outstanding"}, 64'(left), 64'(0));
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_snk_ready"}, 64'(snk_ready), 64'(0));
    check({nm, "_srt"}, 64'({srt_valid, srt_sop, srt_eop, srt_data}), 64'(0));
    check({nm, "_src"}, 64'({res_ready, src_valid, src_sop, src_eop, src_data, src_ch, trunc}), 64'(0));
  endtask

  initial begin
    int base;
    bit hit;
    repeat (3) @(negedge clk);
    #2;
    check_outputs_zero("reset");
    arst = 1'b0;

    // 8-word packet on ch0
    pkt = '{16'd5, 16'd3, 16'd7, 16'd1, 16'd8, 16'd2, 16'd6, 16'd4}; push_pkt(0, 8);
    srtd = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}; push_res(0);
    wait_done("t1", 500);
    check("t1_trunc_cnt", 64'(trunc_cnt), 64'(0));

    // single-word packet on ch1
    pkt = '{16'h00AA}; push_pkt(1, 1);
    srtd = '{16'h00AA}; push_res(1);
    wait_done("single", 200);

    // 300-word packet on ch2 (truncated), ch3 waiting, downstream ready toggling
    pkt.delete();
    for (int i = 0; i < 300; i++) pkt.push_back(16'(300 - i));
    push_pkt(2, MAXL);
    srtd.delete();
    for (int k = 0; k < 250; k++) srtd.push_back(16'(51 + k));
    push_res(2);
    pkt = '{16'h0030, 16'h0010, 16'h0020}; push_pkt(3, 3);
    srtd = '{16'h0010, 16'h0020, 16'h0030}; push_res(3);
    toggle_mode = 1;
    wait_done("trunc", 5000);
    toggle_mode = 0;
    check("trunc_cnt", 64'(trunc_cnt), 64'(1));

    // all four channels, two packets each: service order 0,1,2,3,0,1,2,3
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NC; c++) begin
        pkt  = '{16'(c*16 + p*256 + 3), 16'(c*16 + p*256 + 1), 16'(c*16 + p*256 + 2)};
        push_pkt(c, 3);
        srtd = '{16'(c*16 + p*256 + 1), 16'(c*16 + p*256 + 2), 16'(c*16 + p*256 + 3)};
        push_res(c);
      end
    wait_done("rr", 2000);
    check("rr_trunc_cnt", 64'(trunc_cnt), 64'(1));

    // reset while the 4th word of a ch0 packet is on the sorter sink
    pkt = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105,
            16'h0106, 16'h0107, 16'h0108, 16'h0109, 16'h010A};
    push_pkt(0, 3);
    base = srt_cnt; hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #2;
      if (srt_cnt >= base + 3) begin hit = 1; break; end
    end
    check("rst_reach_word4", 64'(hit), 64'(1));
    @(posedge clk); #1;
    arst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    #2;
    for (int c = 0; c < NC; c++) ch_q[c].delete();
    check("midrst_srt_words_left", 64'(exp_srt.size()), 64'(0));
    exp_srt.delete(); exp_src.delete();
    arst = 1'b0;
    pkt = '{16'd9, 16'd4}; push_pkt(0, 2);
    srtd = '{16'd4, 16'd9}; push_res(0);
    pkt = '{16'd7, 16'd6}; push_pkt(1, 2);
    srtd = '{16'd6, 16'd7}; push_res(1);
    wait_done("post_rst", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t, required < 500000", $time);
    $fatal(1, "timeout");
  end

endmodule
